// File: rtl/decode_queue.sv
// decode_queue: buffered instruction-decode stage between IF and EX.
// Fetched {pc, instr} words are accepted on a valid/ready handshake and held
// in a DEPTH-entry FIFO. One registered decoded bundle is presented to EX
// per cycle. An empty queue with a free output register bypasses the FIFO,
// so the instruction is visible one cycle after it is accepted.
// Optional feature macro: DECODE_ILLEGAL_CHECK_EN. When it is defined, the
// illegal-instruction check is built in. When it is undefined, illegal_o is
// always 0.
module decode_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic [31:0]     in_instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      op_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_LOAD      = 7'h03;
    localparam logic [6:0] OP_ARITH_IMM = 7'h13;
    localparam logic [6:0] OP_AUIPC     = 7'h17;
    localparam logic [6:0] OP_STORE     = 7'h23;
    localparam logic [6:0] OP_ARITH_REG = 7'h33;
    localparam logic [6:0] OP_LUI       = 7'h37;
    localparam logic [6:0] OP_BRANCH    = 7'h63;
    localparam logic [6:0] OP_JALR      = 7'h67;
    localparam logic [6:0] OP_JAL       = 7'h6F;

    // FIFO storage and bookkeeping
    logic [XLEN-1:0] pc_mem_q  [DEPTH];
    logic [31:0]     ins_mem_q [DEPTH];
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            rdy_q;

    // output bundle registers
    logic            out_valid_q;
    logic [XLEN-1:0] pc_q, imm_q;
    logic [6:0]      op_q, funct7_q;
    logic [4:0]      rd_q, rs1_q, rs2_q;
    logic [2:0]      funct3_q;
    logic            illegal_q;

    logic accept, load_out, pop, bypass, push, fifo_nonempty;

    // ready is derived from registered state only; rdy_q holds it low through reset
    assign in_ready_o    = rdy_q & (count_q < CW'(DEPTH));
    assign fifo_nonempty = (count_q != '0);
    assign accept        = in_valid_i & in_ready_o & ~flush_i;
    assign load_out      = ~out_valid_q | out_ready_i;
    assign pop           = load_out & fifo_nonempty;
    assign bypass        = accept & load_out & ~fifo_nonempty;
    assign push          = accept & ~bypass;

    // decode source: FIFO head if anything is queued, else the incoming word
    logic [XLEN-1:0] src_pc;
    logic [31:0]     src_ins;
    assign src_pc  = fifo_nonempty ? pc_mem_q[rd_ptr_q]  : in_pc_i;
    assign src_ins = fifo_nonempty ? ins_mem_q[rd_ptr_q] : in_instr_i;

    logic [6:0]  dec_opc, dec_f7raw;
    logic [2:0]  dec_f3raw;
    assign dec_opc   = src_ins[6:0];
    assign dec_f3raw = src_ins[14:12];
    assign dec_f7raw = src_ins[31:25];

    logic [4:0]      dec_rd, dec_rs1, dec_rs2;
    logic [2:0]      dec_f3;
    logic [6:0]      dec_f7;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    // combinational field extraction per instruction format
    always_comb begin
        dec_rd    = '0;
        dec_rs1   = '0;
        dec_rs2   = '0;
        dec_f3    = '0;
        dec_f7    = '0;
        dec_imm32 = '0;
        dec_ill   = 1'b0;
        case (dec_opc)
            OP_LOAD, OP_JALR, OP_ARITH_IMM: begin
                dec_rd    = src_ins[11:7];
                dec_rs1   = src_ins[19:15];
                dec_f3    = dec_f3raw;
                dec_imm32 = {{20{src_ins[31]}}, src_ins[31:20]};
                // shift-immediate forms carry funct7 in the upper imm bits
                if (dec_opc == OP_ARITH_IMM && (dec_f3raw == 3'd1 || dec_f3raw == 3'd5))
                    dec_f7 = dec_f7raw;
            end
            OP_STORE: begin
                dec_rs1   = src_ins[19:15];
                dec_rs2   = src_ins[24:20];
                dec_f3    = dec_f3raw;
                dec_imm32 = {{20{src_ins[31]}}, src_ins[31:25], src_ins[11:7]};
            end
            OP_BRANCH: begin
                dec_rs1   = src_ins[19:15];
                dec_rs2   = src_ins[24:20];
                dec_f3    = dec_f3raw;
                dec_imm32 = {{20{src_ins[31]}}, src_ins[7], src_ins[30:25],
                             src_ins[11:8], 1'b0};
            end
            OP_JAL: begin
                dec_rd    = src_ins[11:7];
                dec_imm32 = {{12{src_ins[31]}}, src_ins[19:12], src_ins[20],
                             src_ins[30:21], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec_rd    = src_ins[11:7];
                dec_imm32 = {src_ins[31:12], 12'b0};
            end
            OP_ARITH_REG: begin
                dec_rd  = src_ins[11:7];
                dec_rs1 = src_ins[19:15];
                dec_rs2 = src_ins[24:20];
                dec_f3  = dec_f3raw;
                dec_f7  = dec_f7raw;
            end
            default: ;
        endcase
`ifdef DECODE_ILLEGAL_CHECK_EN
        case (dec_opc)
            OP_LOAD:      dec_ill = (dec_f3raw == 3'd3) || (dec_f3raw >= 3'd6);
            OP_STORE:     dec_ill = (dec_f3raw > 3'd2);
            OP_BRANCH:    dec_ill = (dec_f3raw == 3'd2) || (dec_f3raw == 3'd3);
            OP_JALR:      dec_ill = (dec_f3raw != 3'd0);
            OP_ARITH_REG: dec_ill = !((dec_f7raw == 7'h00) ||
                                      (dec_f7raw == 7'h20 &&
                                       (dec_f3raw == 3'd0 || dec_f3raw == 3'd5)));
            OP_ARITH_IMM, OP_JAL, OP_LUI, OP_AUIPC: dec_ill = 1'b0;
            default:      dec_ill = 1'b1;
        endcase
        if (src_ins[1:0] != 2'b11)
            dec_ill = 1'b1;
        // illegal bundles still flow, but carry no operand information
        if (dec_ill) begin
            dec_rd    = '0;
            dec_rs1   = '0;
            dec_rs2   = '0;
            dec_f3    = '0;
            dec_f7    = '0;
            dec_imm32 = '0;
        end
`endif
    end

    assign dec_imm = XLEN'($signed(dec_imm32));

    // next-state for FIFO pointers and occupancy; flush wins over push/pop
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= 1'b1;
        end
    end

    // FIFO payload storage; contents are meaningless unless counted
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= in_pc_i;
            ins_mem_q[wr_ptr_q] <= in_instr_i;
        end
    end

    // output bundle register: loads whenever EX is not stalling a valid bundle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            imm_q       <= '0;
            illegal_q   <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= pop | bypass;
            pc_q        <= src_pc;
            op_q        <= dec_opc;
            rd_q        <= dec_rd;
            rs1_q       <= dec_rs1;
            rs2_q       <= dec_rs2;
            funct3_q    <= dec_f3;
            funct7_q    <= dec_f7;
            imm_q       <= dec_imm;
            illegal_q   <= dec_ill;
        end
    end

    assign out_valid_o = out_valid_q;
    assign pc_o        = pc_q;
    assign op_o        = op_q;
    assign rd_o        = rd_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign funct3_o    = funct3_q;
    assign funct7_o    = funct7_q;
    assign imm_o       = imm_q;
    assign illegal_o   = illegal_q;

endmodule
